// File: rtl/sram_mp_pkg.sv
// sram_mp_pkg: shared defaults, FSM state type and byte-merge helper for the
// multi-port frame-block SRAM controller.
package sram_mp_pkg;
    localparam int DEF_DATA_WIDTH   = 2048;
    localparam int DEF_ADDR_WIDTH   = 12;
    localparam int DEF_NUM_RD_PORTS = 2;
    localparam int DEF_RD_LATENCY   = 1;
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;
    function automatic logic [7:0] byte_merge(logic [7:0] old_byte, logic [7:0] new_byte,
                                              logic mask_bit);
        return mask_bit ? new_byte : old_byte;
    endfunction
endpackage

// File: rtl/sram_mp_rd_pipe.sv
// sram_mp_rd_pipe: captures the read word on an accepted request and delays
// data and valid together by RD_LATENCY (1 or 2) cycles.
module sram_mp_rd_pipe #(
    parameter int DATA_WIDTH = 2048,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [DATA_WIDTH-1:0] rd_word,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dvalid
);
    logic [DATA_WIDTH-1:0] s1_q, s1_d, s2_q, s2_d;
    logic                  v1_q, v1_d, v2_q, v2_d;
    // Stages only load on a valid so dout holds the last returned word.
    always_comb begin
        s1_d = req ? rd_word : s1_q;
        v1_d = req;
        s2_d = v1_q ? s1_q : s2_q;
        v2_d = v1_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end
    assign dout   = (RD_LATENCY == 2) ? s2_q : s1_q;
    assign dvalid = (RD_LATENCY == 2) ? v2_q : v1_q;
endmodule

// File: rtl/sram_mp_ctrl.sv
// sram_mp_ctrl: one R/W port plus NUM_RD_PORTS read ports over a cleared-on-reset
// array. Define SRAM_MP_BYPASS_EN for write-first collisions (read-first otherwise).
module sram_mp_ctrl
    import sram_mp_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
    parameter int NUM_WMASKS   = DATA_WIDTH / 8,
    parameter int NUM_RD_PORTS = DEF_NUM_RD_PORTS,
    parameter int RD_LATENCY   = DEF_RD_LATENCY
) (
    input  logic                               clk,
    input  logic                               reset,
    output logic                               busy,
    input  logic                               csb0,
    input  logic                               web0,
    input  logic [NUM_WMASKS-1:0]              wmask0,
    input  logic [ADDR_WIDTH-1:0]              addr0,
    input  logic [DATA_WIDTH-1:0]              din0,
    output logic [DATA_WIDTH-1:0]              dout0,
    output logic                               dvalid0,
    input  logic [NUM_RD_PORTS-1:0]            rd_csb,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_dout,
    output logic [NUM_RD_PORTS-1:0]            rd_dvalid,
    output logic                               collision
);
    localparam int NP = NUM_RD_PORTS + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(RAM_DEPTH - 1);
    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  collision_q, collision_d;
    logic                  run, wr_en;
    logic [DATA_WIDTH-1:0] old_word, new_word;
    logic [NP-1:0]         req, hit, dvalid_p;
    logic [ADDR_WIDTH-1:0] addr [NP];
    logic [DATA_WIDTH-1:0] word [NP];
    logic [DATA_WIDTH-1:0] dout_p [NP];
    // Index 0 is the R/W port; index p+1 is read port p.
    always_comb begin
        run      = state_q == ST_RUN;
        wr_en    = run && !csb0 && !web0;
        old_word = mem_q[addr0];
        new_word = old_word;
        for (int i = 0; i < NUM_WMASKS; i++)
            new_word[8*i +: 8] = byte_merge(old_word[8*i +: 8], din0[8*i +: 8], wmask0[i]);
        state_d = (!run && cnt_q == LAST) ? ST_RUN : state_q;
        cnt_d   = run ? cnt_q : cnt_q + 1'b1;
        addr[0] = addr0;
        req[0]  = run && !csb0 && web0;
        hit[0]  = 1'b0;
        for (int p = 1; p < NP; p++) begin
            addr[p] = rd_addr[(p-1)*ADDR_WIDTH +: ADDR_WIDTH];
            req[p]  = run && !rd_csb[p-1];
            hit[p]  = wr_en && req[p] && addr[p] == addr0;
        end
        for (int p = 0; p < NP; p++)
`ifdef SRAM_MP_BYPASS_EN
            word[p] = hit[p] ? new_word : mem_q[addr[p]];
`else
            word[p] = mem_q[addr[p]];
`endif
        collision_d = |hit;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            collision_q <= collision_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset && !run)
            mem_q[cnt_q] <= '0;
        else if (!reset && wr_en)
            mem_q[addr0] <= new_word;
    end
    for (genvar k = 0; k < NP; k++) begin : g_port
        sram_mp_rd_pipe #(
            .DATA_WIDTH(DATA_WIDTH),
            .RD_LATENCY(RD_LATENCY)
        ) u_pipe (
            .clk    (clk),
            .reset  (reset),
            .req    (req[k]),
            .rd_word(word[k]),
            .dout   (dout_p[k]),
            .dvalid (dvalid_p[k])
        );
    end
    always_comb begin
        rd_dout   = '0;
        rd_dvalid = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_dout[p*DATA_WIDTH +: DATA_WIDTH] = dout_p[p+1];
            rd_dvalid[p]                        = dvalid_p[p+1];
        end
    end
    assign busy      = !run;
    assign dout0     = dout_p[0];
    assign dvalid0   = dvalid_p[0];
    assign collision = collision_q;
endmodule

// File: doc/sram_mp_ctrl.md
Name: sram_mp_ctrl

Overview:
- Parametrised successor to the frame-block SRAM model: one clock, one read/write port and NUM_RD_PORTS independent read ports.
- Byte write mask honoured, configurable read latency, per-port read-valid strobes, deterministic same-address write/read behaviour.
- Post-reset clear sweep zeroes the array; the block raises busy during the sweep.
- Holds 16x16x8 pixel blocks for the 80x45-block frame store; feeds the block-matching datapath.

Parameters:
- DATA_WIDTH, 2048, bits per word (16x16 pixels x 8 bit); must be a multiple of 8.
- ADDR_WIDTH, 12, word address bits.
- RAM_DEPTH, 1<<ADDR_WIDTH, number of words.
- NUM_WMASKS, DATA_WIDTH/8, byte-enable bits.
- NUM_RD_PORTS, 2, read-only ports, 1..4.
- RD_LATENCY, 1, request-to-dout cycles, 1 or 2.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- busy  out  1  high while the clear sweep runs; requests are ignored.
- csb0  in  1  port 0 chip select, active low.
- web0  in  1  port 0 write enable, active low.
- wmask0  in  NUM_WMASKS  byte enables; bit i covers din0[8i+7:8i].
- addr0  in  ADDR_WIDTH  port 0 address.
- din0  in  DATA_WIDTH  write data.
- dout0  out  DATA_WIDTH  port 0 read data.
- dvalid0  out  1  dout0 valid pulse.
- rd_csb  in  NUM_RD_PORTS  read-port selects, active low, bit p = port p.
- rd_addr  in  NUM_RD_PORTS*ADDR_WIDTH  packed addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
- rd_dout  out  NUM_RD_PORTS*DATA_WIDTH  packed read data.
- rd_dvalid  out  NUM_RD_PORTS  per-port valid pulse.
- collision  out  1  pulse: a read port addressed the word port 0 wrote in the same cycle.

Behaviour:
- Reset
  - The cycle after reset is sampled high: all douts are 0, all valids 0, collision 0, busy 1, FSM in CLEAR, clear counter 0.
  - Reset asserted mid-sweep or mid-read restarts CLEAR at address 0 and drops all in-flight reads.
- FSM
  - CLEAR: write zero to mem[cnt] each cycle, cnt++.
  - After cnt == RAM_DEPTH-1 is written, go to RUN and drop busy.
  - The sweep takes exactly RAM_DEPTH cycles.
  - RUN: normal operation. RUN exits only via reset.
- Request accept
  - A request is accepted on a posedge in RUN with csb low.
  - In CLEAR, requests are ignored and produce no valid.
- Write (csb0=0, web0=0)
  - Bytes with wmask0[i]=1 update at that posedge; masked bytes keep their old value.
  - wmask0 all-zero is a no-op.
  - No dvalid0 is produced.
- Read, port 0 (csb0=0, web0=1) or read port p (rd_csb[p]=0)
  - Data and the valid pulse appear RD_LATENCY cycles after the accepting edge.
  - The valid is high for exactly one cycle per request; back-to-back requests give back-to-back valids (full throughput).
  - dout holds its last value when valid is low (no x).
- Same-cycle port 0 write and port p read to the same address
  - collision pulses on the following cycle.
  - Returned data follows the Optional Feature.
  - Multiple read ports reading the same address is always legal, with no collision.
- Latency pipeline
  - RD_LATENCY=2 adds one output register stage per port.
  - Valids are shifted alongside the data.
- Address width
  - Addresses are exactly ADDR_WIDTH bits, so there is no out-of-range access when RAM_DEPTH = 2^ADDR_WIDTH.

Optional Feature:
- Macro: SRAM_MP_BYPASS_EN.
- Defined: on a same-address collision, the read returns the merged new word (written bytes new, masked bytes old). This is write-first.
- Undefined: the read returns the pre-write word. This is read-first.
- collision pulses in both builds.

Decomposition:
- Package sram_mp_pkg:
  - localparams for default widths.
  - FSM state typedef (ST_CLEAR, ST_RUN).
  - Function for the byte-mask merge (old, new, mask).
- One natural sub-module: sram_mp_rd_pipe.
  - Per-port address register, array read, RD_LATENCY data/valid pipeline.
  - Instantiated NUM_RD_PORTS+1 times via generate; the port 0 instance is gated by web0.

Test Plan (DATA_WIDTH=32, ADDR_WIDTH=4, NUM_RD_PORTS=2):
- Reset pulse, then read all 16 addresses on port 1:
  - busy stays high exactly 16 cycles.
  - Every read returns 32'h0.
  - Requests issued during busy produce no rd_dvalid.
- Write addr 3 = 32'hDEADBEEF, wmask 4'b1111; then write addr 3 = 32'h11223344, wmask 4'b0101; read port 0:
  - Result is 32'hDE22BE44.
  - dvalid0 arrives RD_LATENCY cycles after the request.
- Streaming reads, 8 consecutive cycles on ports 1 and 2 (addr 0..7 and 7..0), RD_LATENCY=2:
  - 8 consecutive valids per port.
  - Data in order.
  - No bubbles.
- Same cycle: write addr 5 = 32'hA5A5A5A5 (old 32'h0) and port 1 read addr 5:
  - collision=1 the next cycle.
  - Data is 32'hA5A5A5A5 with SRAM_MP_BYPASS_EN, 32'h0 without.
- Reset asserted at sweep count 7, and again with a read in flight:
  - Sweep restarts; busy is high 16 cycles from the new reset.
  - The in-flight read yields no valid.
- Port 1 and port 2 read addr 9 in the same cycle with no write:
  - Both return identical data.
  - collision stays 0.
